i2c_prog_master: RTL and testbench

Byte-level I2C master that drives the instruction-memory programming port of the simple processor from the host side. It issues write transactions (device address, memory address, data) and read-back transactions (device address, memory address, repeated START, device address + R, one data byte), with open-drain SCL/SDA outputs. It is used on the test/loader side of the pins `ext_sda_in`/`ext_scl_in` to load and verify program memory.

---
 rtl/i2c_prog_master.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_prog_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_prog_master.sv
// Byte-level I2C master for loading and verifying the instruction memory.
// It runs write transactions (dev addr, mem addr, data) and read-back
// transactions (dev addr, mem addr, repeated START, dev addr + R, one byte).
// SCL/SDA are open-drain: an *_oe of 1 pulls the line low.
module i2c_prog_master #(
   parameter int         CLK_DIV    = 25,
   parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_rw,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_wdata,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_scl_oe,
   output logic       o_sda_oe,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_nack,
   output logic [7:0] o_rdata
);

   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_TX_BYTE,
      ST_RX_ACK,
      ST_RSTART,
      ST_RX_BYTE,
      ST_TX_NACK,
      ST_STOP,
      ST_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] qcnt;      // cycles within the current quarter
   logic [1:0]    qtr;       // quarter index within the current bit / condition
   logic [2:0]    bitcnt;    // bit index within a data byte
   logic [1:0]    phase;     // acked bytes so far: 0 dev addr, 1 mem addr, 2 third byte
   logic          rw_q;
   logic [7:0]    addr_q;
   logic [7:0]    wdata_q;
   logic [7:0]    txsh;      // outgoing byte, MSB on the wire
   logic [7:0]    rxsh;      // incoming byte
   logic          samp;      // SDA level sampled at the end of Q2
   logic          nack_q;
   logic [7:0]    rdata_q;

   logic active, freeze, tick, bit_end, last_bit, accept, bit_scl_low;

   // IDLE and DONE keep the quarter counter parked; everything else is on the bus.
   assign active      = (state != ST_IDLE) && (state != ST_DONE);
   // A slave holding SCL low in Q1 keeps the counter at 0 (clock stretching).
   assign freeze      = active && (qtr == 2'd1) && (qcnt == '0) && !i_scl;
   assign tick        = active && !freeze && (qcnt == QMAX);
   assign bit_end     = tick && (qtr == 2'd3);
   assign last_bit    = (bitcnt == 3'd7);
   assign accept      = (state == ST_IDLE) && i_start;
   assign bit_scl_low = (qtr == 2'd0) || (qtr == 2'd3);

   assign o_busy  = active;
   assign o_done  = (state == ST_DONE);
   assign o_nack  = nack_q;
   assign o_rdata = rdata_q;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state sequencing and open-drain line drive per quarter.
   always_comb begin
      state_nxt = state;
      o_scl_oe  = 1'b0;
      o_sda_oe  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) state_nxt = ST_START;
         end
         ST_START, ST_RSTART: begin
            // released, held, SDA falls under high SCL, then SCL low
            o_scl_oe = (qtr == 2'd3);
            o_sda_oe = qtr[1];
            if (bit_end) state_nxt = ST_TX_BYTE;
         end
         ST_TX_BYTE: begin
            o_scl_oe = bit_scl_low;
            o_sda_oe = !txsh[7];
            if (bit_end && last_bit) state_nxt = ST_RX_ACK;
         end
         ST_RX_ACK: begin
            o_scl_oe = bit_scl_low;
            if (bit_end) begin
               if (samp) begin
                  state_nxt = ST_STOP;
               end else begin
                  case (phase)
                     2'd0:    state_nxt = ST_TX_BYTE;
                     2'd1:    state_nxt = rw_q ? ST_RSTART : ST_TX_BYTE;
                     default: state_nxt = rw_q ? ST_RX_BYTE : ST_STOP;
                  endcase
               end
            end
         end
         ST_RX_BYTE: begin
            o_scl_oe = bit_scl_low;
            if (bit_end && last_bit) state_nxt = ST_TX_NACK;
         end
         ST_TX_NACK: begin
            o_scl_oe = bit_scl_low;
            if (bit_end) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            // SDA low with SCL low, release SCL, hold, SDA rises under high SCL
            o_scl_oe = (qtr == 2'd0);
            o_sda_oe = (qtr != 2'd3);
            if (bit_end) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Quarter timing: CLK_DIV cycles per quarter, frozen while SCL is stretched.
   always_ff @(posedge i_clk) begin
      if (i_rst || !active) begin
         qcnt <= '0;
         qtr  <= 2'd0;
      end else if (tick) begin
         qcnt <= '0;
         qtr  <= qtr + 2'd1;
      end else if (!freeze) begin
         qcnt <= qcnt + CW'(1);
      end
   end

   // Bit index inside a byte; wraps to 0 after bit 7.
   always_ff @(posedge i_clk) begin
      if (i_rst || !active) begin
         bitcnt <= 3'd0;
      end else if (bit_end && ((state == ST_TX_BYTE) || (state == ST_RX_BYTE))) begin
         bitcnt <= bitcnt + 3'd1;
      end
   end

   // Request capture, shift registers, sticky NACK and read-data register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rw_q    <= 1'b0;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         phase   <= 2'd0;
         txsh    <= 8'h00;
         rxsh    <= 8'h00;
         samp    <= 1'b0;
         nack_q  <= 1'b0;
         rdata_q <= 8'h00;
      end else begin
         if (accept) begin
            rw_q    <= i_rw;
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            phase   <= 2'd0;
            nack_q  <= 1'b0;
         end

         if (tick && (qtr == 2'd2)) begin
            samp <= i_sda;
            if (state == ST_RX_BYTE) rxsh <= {rxsh[6:0], i_sda};
         end

         if (bit_end) begin
            case (state)
               ST_START:   txsh <= {SLAVE_ADDR, 1'b0};
               ST_RSTART:  txsh <= {SLAVE_ADDR, 1'b1};
               ST_TX_BYTE: txsh <= {txsh[6:0], 1'b0};
               ST_RX_ACK: begin
                  // only used when the next state is TX_BYTE
                  txsh <= (phase == 2'd0) ? addr_q : wdata_q;
                  if (samp) nack_q <= 1'b1;
                  else      phase  <= phase + 2'd1;
               end
               ST_RX_BYTE: begin
                  if (last_bit) rdata_q <= rxsh;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_prog_master.sv
// Directed bench for i2c_prog_master: an event-level I2C slave/monitor on the
// wired-AND bus, a transaction-level timing model checked every cycle, and
// hand-computed expectations for bytes, latencies, NACK and read data.
module tb_i2c_prog_master;

   localparam int CLK_DIV = 4;
   localparam int EV_S    = 256;
   localparam int EV_P    = 257;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0;
   logic       i_rw = 1'b0;
   logic [7:0] i_addr = 8'h00;
   logic [7:0] i_wdata = 8'h00;
   logic       i_scl, i_sda;
   logic       o_scl_oe, o_sda_oe, o_busy, o_done, o_nack;
   logic [7:0] o_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   i2c_prog_master #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'h2A)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rw(i_rw),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_scl(i_scl), .i_sda(i_sda),
      .o_scl_oe(o_scl_oe), .o_sda_oe(o_sda_oe), .o_busy(o_busy),
      .o_done(o_done), .o_nack(o_nack), .o_rdata(o_rdata)
   );

   // wired-AND bus with pull-ups
   logic s_scl_low = 1'b0;
   logic s_sda_low = 1'b0;
   assign i_scl = !(o_scl_oe || s_scl_low);
   assign i_sda = !(o_sda_oe || s_sda_low);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- slave / bus monitor ----------------
   int         bus_log[$];
   int         exp_log[$];
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   int         bitn = 0;
   logic       first_byte = 1'b1, slave_tx = 1'b0, pend_rd = 1'b0;
   logic [7:0] sh = 8'h00;
   logic [7:0] rd_val = 8'h3C;
   logic       ackv = 1'b0, mack = 1'b0;
   logic       nack_first = 1'b0, stretch_first = 1'b0;
   int         scnt = 0;

   always @(negedge i_clk) begin
      logic l_scl, l_sda;
      l_scl = i_scl;
      l_sda = i_sda;
      if (i_rst) begin
         s_scl_low = 1'b0; s_sda_low = 1'b0;
         bitn = 0; first_byte = 1'b1; slave_tx = 1'b0; pend_rd = 1'b0;
      end else begin
         if (s_scl_low && !o_scl_oe) begin
            if (scnt == 40) s_scl_low = 1'b0;
            else            scnt++;
         end
         if (l_scl && prev_scl && prev_sda && !l_sda) begin
            bus_log.push_back(EV_S);
            bitn = 0; first_byte = 1'b1; slave_tx = 1'b0; pend_rd = 1'b0; s_sda_low = 1'b0;
         end else if (l_scl && prev_scl && !prev_sda && l_sda) begin
            bus_log.push_back(EV_P);
            bitn = 0; first_byte = 1'b1; slave_tx = 1'b0; pend_rd = 1'b0;
         end else if (l_scl && !prev_scl) begin
            if (bitn < 8) sh = {sh[6:0], l_sda};
            else          ackv = l_sda;
            bitn++;
         end else if (!l_scl && prev_scl) begin
            if (bitn == 8) begin
               bus_log.push_back(int'(sh));
               if (slave_tx) begin
                  s_sda_low = 1'b0;
               end else begin
                  s_sda_low = !(nack_first && first_byte);
                  if (first_byte && sh[0]) pend_rd = 1'b1;
                  if (stretch_first && first_byte) begin
                     s_scl_low = 1'b1; scnt = 0; stretch_first = 1'b0;
                  end
               end
               first_byte = 1'b0;
            end else if (bitn == 9) begin
               bitn = 0;
               if (slave_tx) mack = ackv;
               slave_tx  = pend_rd;
               s_sda_low = pend_rd ? !rd_val[7] : 1'b0;
               pend_rd   = 1'b0;
            end else if (slave_tx && bitn >= 1 && bitn <= 7) begin
               s_sda_low = !rd_val[7-bitn];
            end
         end
      end
      prev_scl = l_scl;
      prev_sda = l_sda;
   end

   // ---------------- transaction timing model ----------------
   logic m_active = 1'b0;
   int   m_n = 0;
   int   m_lat = 0;

   // busy/done/line-release checked every cycle against the model
   always @(negedge i_clk) begin
      logic eb, ed;
      if (!i_rst) begin
         eb = m_active && (cyc >= m_n) && (cyc < m_n + m_lat);
         ed = m_active && (cyc == m_n + m_lat);
         chk("busy", o_busy, eb);
         chk("done", o_done, ed);
         if (!eb) begin
            chk("scl_idle", o_scl_oe, 1'b0);
            chk("sda_idle", o_sda_oe, 1'b0);
         end
      end
   end

   // quarters: START/RSTART/STOP 4, one byte + ack 36, read byte 32, master NACK 4
   function automatic int quarters(input logic rw, input logic nack);
      if (nack)    return 4 + 36 + 4;
      else if (rw) return 4 + 36 + 36 + 4 + 36 + 32 + 4 + 4;
      else         return 4 + 36 + 36 + 36 + 4;
   endfunction

   task automatic build_exp(input logic rw, input logic [7:0] a, input logic [7:0] d,
                            input logic nack, input logic [7:0] rd);
      exp_log.delete();
      exp_log.push_back(EV_S);
      exp_log.push_back(int'({7'h2A, 1'b0}));
      if (!nack) begin
         exp_log.push_back(int'(a));
         if (rw) begin
            exp_log.push_back(EV_S);
            exp_log.push_back(int'({7'h2A, 1'b1}));
            exp_log.push_back(int'(rd));
         end else begin
            exp_log.push_back(int'(d));
         end
      end
      exp_log.push_back(EV_P);
   endtask

   task automatic chk_log(input string name);
      checks++;
      if (bus_log.size() != exp_log.size()) begin
         errors++;
         $display("FAIL %s log length: got %0d expected %0d", name, bus_log.size(), exp_log.size());
      end else begin
         foreach (exp_log[i]) chk(name, bus_log[i], exp_log[i]);
      end
   endtask

   task automatic start_txn(input logic rw, input logic [7:0] a, input logic [7:0] d,
                            input logic nack, input int ext);
      repeat (3) @(posedge i_clk);
      #1;
      i_start = 1'b1; i_rw = rw; i_addr = a; i_wdata = d;
      bus_log.delete();
      @(posedge i_clk);
      #1;
      i_start = 1'b0; i_addr = 8'hFF; i_wdata = 8'h00; i_rw = !rw;
      m_n = cyc; m_lat = quarters(rw, nack) * CLK_DIV + ext; m_active = 1'b1;
   endtask

   task automatic wait_done(input string name, input int bound, output int meas);
      int k = 0;
      meas = -1;
      while (k < bound) begin
         @(negedge i_clk);
         k++;
         if (o_done) begin
            meas = cyc - m_n + 1;
            break;
         end
      end
      checks++;
      if (meas < 0) begin
         errors++;
         $display("FAIL %s done timeout: got none expected within %0d cycles", name, bound);
      end
   endtask

   initial begin
      int lat;
      int k;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_scl_oe", o_scl_oe, 1'b0);
      chk("rst_sda_oe", o_sda_oe, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_nack", o_nack, 1'b0);
      chk("rst_rdata", o_rdata, 8'h00);

      // write 10/A5 with a start pulse mid-transfer that must be ignored
      start_txn(1'b0, 8'h10, 8'hA5, 1'b0, 0);
      repeat (150) @(posedge i_clk);
      #1 i_start = 1'b1; i_rw = 1'b1; i_addr = 8'h00; i_wdata = 8'h00;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      wait_done("wr", 2000, lat);
      chk("wr_latency", lat, 465);
      chk("wr_nack", o_nack, 1'b0);
      @(posedge i_clk); #1;
      build_exp(1'b0, 8'h10, 8'hA5, 1'b0, 8'h00);
      chk_log("wr_bus");
      chk("wr_byte0", bus_log[1], 32'h54);
      chk("wr_byte2", bus_log[3], 32'hA5);

      // NACK on the address byte, start held high into DONE: taken one cycle later
      nack_first = 1'b1;
      start_txn(1'b0, 8'h10, 8'hA5, 1'b1, 0);
      repeat (60) @(posedge i_clk);
      #1 i_start = 1'b1; i_rw = 1'b0; i_addr = 8'h22; i_wdata = 8'h5A;
      wait_done("nk", 2000, lat);
      chk("nk_latency", lat, 177);
      chk("nk_nack", o_nack, 1'b1);
      nack_first = 1'b0;
      @(posedge i_clk); #1;
      build_exp(1'b0, 8'h00, 8'h00, 1'b1, 8'h00);
      chk_log("nk_bus");
      bus_log.delete();
      m_n = cyc + 1; m_lat = quarters(1'b0, 1'b0) * CLK_DIV; m_active = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      chk("b2b_nack_clr", o_nack, 1'b0);
      wait_done("b2b", 2000, lat);
      chk("b2b_latency", lat, 465);
      @(posedge i_clk); #1;
      build_exp(1'b0, 8'h22, 8'h5A, 1'b0, 8'h00);
      chk_log("b2b_bus");

      // read-back of address 04, slave returns 3C
      mack = 1'b0;
      start_txn(1'b1, 8'h04, 8'h00, 1'b0, 0);
      wait_done("rd", 3000, lat);
      chk("rd_latency", lat, 625);
      chk("rd_rdata", o_rdata, 8'h3C);
      chk("rd_nack", o_nack, 1'b0);
      @(posedge i_clk); #1;
      chk("rd_master_nack", mack, 1'b1);
      build_exp(1'b1, 8'h04, 8'h00, 1'b0, 8'h3C);
      chk_log("rd_bus");
      chk("rd_byte_r", bus_log[4], 32'h55);

      // 40-cycle clock stretch in the first ACK bit
      stretch_first = 1'b1;
      start_txn(1'b0, 8'h33, 8'hC3, 1'b0, 40);
      wait_done("st", 2000, lat);
      chk("st_latency", lat, 505);
      chk("st_rdata_hold", o_rdata, 8'h3C);
      @(posedge i_clk); #1;
      build_exp(1'b0, 8'h33, 8'hC3, 1'b0, 8'h00);
      chk_log("st_bus");

      // reset inside the data byte, then a clean write
      start_txn(1'b0, 8'h10, 8'h77, 1'b0, 0);
      k = 0;
      while (bus_log.size() < 3 && k < 1000) begin
         @(posedge i_clk);
         k++;
      end
      chk("rr_reached_data", (bus_log.size() >= 3), 1'b1);
      repeat (40) @(posedge i_clk);
      #1 i_rst = 1'b1; m_active = 1'b0;
      @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      chk("rr_scl_oe", o_scl_oe, 1'b0);
      chk("rr_sda_oe", o_sda_oe, 1'b0);
      chk("rr_busy", o_busy, 1'b0);
      chk("rr_rdata", o_rdata, 8'h00);
      start_txn(1'b0, 8'h10, 8'hA5, 1'b0, 0);
      wait_done("rr_wr", 2000, lat);
      chk("rr_wr_latency", lat, 465);
      @(posedge i_clk); #1;
      build_exp(1'b0, 8'h10, 8'hA5, 1'b0, 8'h00);
      chk_log("rr_wr_bus");

      repeat (5) @(posedge i_clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
